// File: rtl/gf192_addsub_issuer.sv
// Initiator for the 192-bit modular add/sub unit: buffers tagged commands in a FIFO,
// issues them one at a time to the adder and returns results with a completion watchdog.
module gf192_addsub_issuer #(
    parameter int unsigned BW_GF   = 192,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [BW_GF-1:0] cmd_a,
    input  logic [BW_GF-1:0] cmd_b,
    input  logic             cmd_is_sub,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             add_en,
    output logic [BW_GF-1:0] add_a,
    output logic [BW_GF-1:0] add_b,
    output logic             add_is_sub,
    input  logic [BW_GF-1:0] add_out,
    input  logic             add_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BW_GF-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             spurious
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    typedef struct packed {
        logic [BW_GF-1:0] a;
        logic [BW_GF-1:0] b;
        logic             is_sub;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             push, pop;

    state_e           state_q, state_d;
    cmd_t             op_q, op_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [BW_GF-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;
    logic             spurious_q, spurious_d;

    // cmd_ready is a registered !full, so a same-cycle pop never admits a push into a full FIFO
    always_comb begin
        cmd_in   = '{a: cmd_a, b: cmd_b, is_sub: cmd_is_sub, tag: cmd_tag};
        push     = cmd_valid && cmd_ready_q;
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        cmd_ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        op_d       = op_q;
        wdog_d     = wdog_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        spurious_d = spurious_q || (add_valid && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    op_d    = head;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a completion on the expiry cycle still counts as success
                if (add_valid) begin
                    rsp_data_d = add_out;
                    rsp_tag_d  = op_q.tag;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    rsp_data_d = '0;
                    rsp_tag_d  = op_q.tag;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        op_d    = head;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
            op_q        <= '0;
            wdog_q      <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            op_q        <= op_d;
            wdog_q      <= wdog_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            spurious_q  <= spurious_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign add_en     = (state_q == ISSUE);
    assign add_a      = op_q.a;
    assign add_b      = op_q.b;
    assign add_is_sub = op_q.is_sub;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign spurious   = spurious_q;

endmodule

// File: tb/tb_gf192_addsub_issuer.sv
// Directed scoreboard bench for gf192_addsub_issuer with a behavioural modular adder.
`timescale 1ns/1ps
module tb_gf192_addsub_issuer;

    localparam logic [191:0] PRIME =
        {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [191:0] PM1 = PRIME - 192'd1;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [191:0] cmd_a;
    logic [191:0] cmd_b;
    logic         cmd_is_sub;
    logic [3:0]   cmd_tag;
    logic         add_en;
    logic [191:0] add_a;
    logic [191:0] add_b;
    logic         add_is_sub;
    logic [191:0] add_out;
    logic         add_valid;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [191:0] rsp_data;
    logic [3:0]   rsp_tag;
    logic         rsp_err;
    logic         spurious;

    gf192_addsub_issuer #(
        .BW_GF(192), .TAG_W(4), .DEPTH(2), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_is_sub(cmd_is_sub), .cmd_tag(cmd_tag),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_is_sub(add_is_sub),
        .add_out(add_out), .add_valid(add_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .spurious(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [191:0] data;
        logic [3:0]   tag;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   adder_lat = 1;   // 0: adder never completes
    logic spur_req = 1'b0;
    logic [191:0] adder_res;
    logic prev_en = 1'b0;

    task automatic check(input string name, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    function automatic logic [191:0] ref_op(input logic [191:0] a, input logic [191:0] b,
                                            input logic sub);
        logic [192:0] s;
        if (sub) begin
            s = {1'b0, a} - {1'b0, b};
            if (a < b) s = s + {1'b0, PRIME};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        end
        return s[191:0];
    endfunction

    function automatic logic [191:0] rand_fe();
        logic [191:0] x;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (x >= PRIME) x = x - PRIME;
        return x;
    endfunction

    // Behavioural adder: completes adder_lat cycles after the issue pulse
    initial begin
        add_valid = 1'b0;
        add_out   = '0;
        forever begin
            @(negedge clk);
            if (spur_req) begin
                add_valid = 1'b1;
                add_out   = 192'h1234;
                @(negedge clk);
                add_valid = 1'b0;
                add_out   = '0;
                spur_req  = 1'b0;
            end else if (add_en === 1'b1 && adder_lat > 0) begin
                adder_res = ref_op(add_a, add_b, add_is_sub);
                repeat (adder_lat) @(negedge clk);
                add_valid = 1'b1;
                add_out   = adder_res;
                @(negedge clk);
                add_valid = 1'b0;
                add_out   = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (add_en === 1'b1) check("add_en_single_cycle", prev_en, 1'b0);
        prev_en <= add_en;
    end

    task automatic send_cmd(input logic [191:0] a, input logic [191:0] b, input logic sub,
                            input logic [3:0] tag, input logic [191:0] exp_data,
                            input logic exp_err, input bit expect_rsp);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_a      = a;
        cmd_b      = b;
        cmd_is_sub = sub;
        cmd_tag    = tag;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        if (expect_rsp) sb.push_back('{exp_data, tag, exp_err});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name);
        int n = 0;
        exp_t e;
        rsp_ready = 1'b1;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, rsp_valid, 1'b1);
        if (rsp_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL %s_unexpected: observed response tag %0h, required none", name, rsp_tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({name, "_data"}, rsp_data, e.data);
                check({name, "_tag"}, rsp_tag, e.tag);
                check({name, "_err"}, rsp_err, e.err);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_drop"}, rsp_valid, 1'b0);
    endtask

    task automatic wait_add_en(input string name);
        int n = 0;
        while (add_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, add_en, 1'b1);
    endtask

    task automatic cycles_to_rsp(input string name, input int exp_cycles);
        int m = 0;
        while (rsp_valid !== 1'b1 && m < 40) begin
            @(negedge clk);
            m++;
        end
        check(name, m, exp_cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [191:0] a, b;
        logic         s;
        bit           seen;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_is_sub = 1'b0; cmd_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_add_en", add_en, 1'b0);
        check("rst_add_a", add_a, '0);
        check("rst_add_b", add_b, '0);
        check("rst_add_is_sub", add_is_sub, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_tag", rsp_tag, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_spurious", spurious, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // add wrap, with 2-cycle issue latency from an empty FIFO
        adder_lat = 1;
        send_cmd(PM1, 192'd1, 1'b0, 4'd3, 192'd0, 1'b0, 1'b1);
        check("lat_add_en_early", add_en, 1'b0);
        @(negedge clk);
        check("lat_add_en", add_en, 1'b1);
        check("issue_add_a", add_a, PM1);
        check("issue_add_b", add_b, 192'd1);
        get_rsp("add_wrap");

        send_cmd(192'd0, 192'd1, 1'b1, 4'd5, PM1, 1'b0, 1'b1);
        get_rsp("sub_underflow");

        // backpressure: one in flight plus two queued fills the unit
        adder_lat = 2;
        for (int i = 0; i < 3; i++) begin
            a = rand_fe(); b = rand_fe(); s = i[0];
            send_cmd(a, b, s, 4'(i), ref_op(a, b, s), 1'b0, 1'b1);
        end
        check("full_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_tag = 4'd9;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full_stall", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        check("bp_rsp_held", rsp_valid, 1'b1);
        check("bp_rsp_tag_held", rsp_tag, 4'd0);
        get_rsp("bp0");
        check("bp_ready_back", cmd_ready, 1'b1);
        get_rsp("bp1");
        get_rsp("bp2");

        for (int i = 0; i < 4; i++) begin
            adder_lat = 1 + (i % 4);
            a = rand_fe(); b = rand_fe(); s = i[1];
            send_cmd(a, b, s, 4'(8 + i), ref_op(a, b, s), 1'b0, 1'b1);
            get_rsp("rand");
        end

        // watchdog expiry, then a late completion
        adder_lat = 0;
        send_cmd(rand_fe(), rand_fe(), 1'b0, 4'd7, 192'd0, 1'b1, 1'b1);
        wait_add_en("to_issue");
        cycles_to_rsp("to_cycles", 16);
        get_rsp("timeout");
        check("spurious_before", spurious, 1'b0);
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_late", spurious, 1'b1);

        // completion on the expiry cycle wins
        adder_lat = 15;
        a = rand_fe(); b = rand_fe();
        send_cmd(a, b, 1'b1, 4'd6, ref_op(a, b, 1'b1), 1'b0, 1'b1);
        wait_add_en("race_issue");
        cycles_to_rsp("race_cycles", 16);
        get_rsp("race");
        check("spurious_sticky", spurious, 1'b1);

        // reset while waiting with a second command queued
        adder_lat = 0;
        send_cmd(rand_fe(), rand_fe(), 1'b0, 4'd10, 192'd0, 1'b0, 1'b0);
        send_cmd(rand_fe(), rand_fe(), 1'b0, 4'd11, 192'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_spurious", spurious, 1'b0);
        check("mid_rst_add_en", add_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        seen = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || add_en === 1'b1) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        check("mid_rst_discard", seen, 1'b0);
        adder_lat = 3;
        a = rand_fe(); b = rand_fe();
        send_cmd(a, b, 1'b0, 4'd12, ref_op(a, b, 1'b0), 1'b0, 1'b1);
        get_rsp("after_rst");
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
